// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state data memory.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic {OP_READ, OP_WRITE} op_t;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_LATENCY    = 2;
   localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;

   // Wide enough to hold LATENCY-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned latency);
      return (latency > 1) ? $clog2(latency) : 1;
   endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Word array with per-byte-lane write enables and a combinational read port.
module mem_byte_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic [DATA_WIDTH/8-1:0] we,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int LANES = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // NOTE: the array has no reset; contents stay undefined until written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/wait_state_memory.sv
// Data memory with a LATENCY-cycle wait state, a one-cycle ready pulse and
// a one-cycle error pulse for conflicting read/write requests.
module wait_state_memory
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int LATENCY    = DEF_LATENCY
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    memRead,
   input  logic                    memWrite,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteEn,
   input  logic [DATA_WIDTH-1:0]   dataIn,
   output logic [DATA_WIDTH-1:0]   dataOut,
   output logic                    busy,
   output logic                    ready,
   output logic                    error
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int CW    = cnt_width(LATENCY);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  accept, commit;

   op_t                   op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LANES-1:0]      be_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic [DATA_WIDTH-1:0] dout_q;

   logic [LANES-1:0]      ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (memRead ^ memWrite) begin
               accept  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end else begin
               err_d   = memRead & memWrite;
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               commit  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_we = (commit && op_q == OP_WRITE) ? be_q : '0;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (commit && op_q == OP_READ) dout_q <= ram_rdata;
      end
   end

   // Request latches: the access uses what was sampled at acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_READ;
         addr_q <= '0;
         be_q   <= '0;
         din_q  <= '0;
      end else if (accept) begin
         op_q   <= memWrite ? OP_WRITE : OP_READ;
         addr_q <= address;
         be_q   <= byteEn;
         din_q  <= dataIn;
      end
   end

   mem_byte_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr_q),
      .wdata (din_q),
      .rdata (ram_rdata)
   );

   assign busy    = (state_q == WAIT);
   assign ready   = (state_q == DONE);
   assign error   = err_q;
   assign dataOut = dout_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Self-checking bench for wait_state_memory: directed vector table, hand
// sequences for multi-cycle corners, and a randomized timestamp-based model.
module tb_wait_state_memory;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int L  = 2;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          memRead, memWrite;
   logic [AW-1:0] address;
   logic [NB-1:0] byteEn;
   logic [DW-1:0] dataIn, dataOut;
   logic          busy, ready, error;

   always #5 clk = ~clk;

   wait_state_memory #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LATENCY    (L)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .memRead  (memRead),
      .memWrite (memWrite),
      .address  (address),
      .byteEn   (byteEn),
      .dataIn   (dataIn),
      .dataOut  (dataOut),
      .busy     (busy),
      .ready    (ready),
      .error    (error)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic b, input logic r,
                             input logic e, input logic [DW-1:0] d);
      check({tag, " busy"},    DW'(busy),  DW'(b));
      check({tag, " ready"},   DW'(ready), DW'(r));
      check({tag, " error"},   DW'(error), DW'(e));
      check({tag, " dataOut"}, dataOut,    d);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [NB-1:0] be, input logic [DW-1:0] d);
      memRead  = rd;
      memWrite = wr;
      address  = a;
      byteEn   = be;
      dataIn   = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          rd, wr;
      logic [AW-1:0] a;
      logic [NB-1:0] be;
      logic [DW-1:0] d;
      logic          b, r, e;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                               input logic [NB-1:0] be, input logic [DW-1:0] d,
                               input logic b, input logic r, input logic e,
                               input logic [DW-1:0] dout);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.be = be; v.d = d;
      v.b = b; v.r = r; v.e = e; v.dout = dout;
      return v;
   endfunction

   // ---------------- reference model (timestamp arithmetic) ----------------
   logic [DW-1:0] mem_m [2**AW];
   logic [DW-1:0] dout_m;
   int            n, acc;
   logic          rq_wr;
   logic [AW-1:0] rq_a;
   logic [NB-1:0] rq_be;
   logic [DW-1:0] rq_d;

   task automatic mcycle(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [NB-1:0] be, input logic [DW-1:0] d);
      logic b_e, r_e, e_e;
      drive(rd, wr, a, be, d);
      @(posedge clk);
      e_e = 1'b0;
      // The block accepts on edge n only if it was not busy in the cycle before.
      if (n >= acc + L + 1) begin
         if (rd ^ wr) begin
            acc = n; rq_wr = wr; rq_a = a; rq_be = be; rq_d = d;
         end else begin
            e_e = rd & wr;
         end
      end
      if (n == acc + L) begin
         if (rq_wr) begin
            for (int i = 0; i < NB; i++)
               if (rq_be[i]) mem_m[rq_a][8*i +: 8] = rq_d[8*i +: 8];
         end else begin
            dout_m = mem_m[rq_a];
         end
      end
      b_e = (n >= acc) && (n < acc + L);
      r_e = (n == acc + L);
      #1;
      check_outs("rnd", b_e, r_e, e_e, dout_m);
      n++;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, '0, '0, '0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset", 0, 0, 0, 32'h0);
      rst_n = 1'b1;

      // Table: full write/read, conflict, byte lanes, empty byteEn
      vecs.push_back(mk(0, 1, 23, 4'hF, 32'd456, 1, 0, 0, 32'd0));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd0));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'd0));
      vecs.push_back(mk(1, 0, 23, 4'h0, 32'd0,   1, 0, 0, 32'd0));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd0));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 0, 0, 32'd456));
      vecs.push_back(mk(1, 1, 23, 4'hF, 32'd99,  0, 0, 1, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 0, 0, 32'd456));
      vecs.push_back(mk(1, 0, 23, 4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'd456));
      vecs.push_back(mk(0, 1, 7,  4'hF, 32'hAABBCCDD, 1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'd456));
      vecs.push_back(mk(0, 1, 7,  4'b0010, 32'h00001100, 1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'd456));
      vecs.push_back(mk(0, 1, 7,  4'h0, 32'hFFFFFFFF, 1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'd456));
      vecs.push_back(mk(1, 0, 7,  4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   1, 0, 0, 32'd456));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 1, 0, 32'hAABB11DD));
      vecs.push_back(mk(0, 0, 0,  4'h0, 32'd0,   0, 0, 0, 32'hAABB11DD));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].be, vecs[i].d);
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].b, vecs[i].r, vecs[i].e, vecs[i].dout);
      end

      // Busy ignore and back-to-back acceptance
      drive(0, 1, 9, 4'hF, 32'h00000099);
      tick(); drive(0, 0, 0, 0, 0);
      tick(); tick();
      check_outs("b2b init", 0, 1, 0, 32'hAABB11DD);
      drive(1, 0, 9, 4'h0, 32'h0);
      tick();
      check_outs("b2b accept", 1, 0, 0, 32'hAABB11DD);
      drive(0, 1, 9, 4'hF, 32'hDEADBEEF);
      tick();
      check_outs("b2b ignored wr", 1, 0, 0, 32'hAABB11DD);
      drive(1, 0, 9, 4'h0, 32'h0);
      tick();
      check_outs("b2b done", 0, 1, 0, 32'h00000099);
      tick();
      check_outs("b2b no gap", 1, 0, 0, 32'h00000099);
      drive(0, 0, 0, 0, 0);
      tick(); tick();
      check_outs("b2b second", 0, 1, 0, 32'h00000099);
      tick();
      check_outs("b2b idle", 0, 0, 0, 32'h00000099);

      // Reset mid-write
      drive(0, 1, 5, 4'hF, 32'h0);
      tick(); drive(0, 0, 0, 0, 0);
      tick(); tick();
      drive(0, 1, 5, 4'hF, 32'h12345678);
      tick(); drive(0, 0, 0, 0, 0);
      tick();
      rst_n = 1'b0;
      #1;
      check_outs("midrst", 0, 0, 0, 32'h0);
      tick(); tick();
      check_outs("midrst hold", 0, 0, 0, 32'h0);
      rst_n = 1'b1;
      drive(1, 0, 9, 4'h0, 32'h0);
      tick(); drive(0, 0, 0, 0, 0);
      tick(); tick();
      check_outs("midrst rd9", 0, 1, 0, 32'h00000099);
      drive(1, 0, 5, 4'h0, 32'h0);
      tick(); drive(0, 0, 0, 0, 0);
      tick(); tick();
      check_outs("midrst rd5", 0, 1, 0, 32'h0);
      tick();

      // Randomized run against the model
      n      = 0;
      acc    = -(L + 1);
      dout_m = 32'h0;
      for (int a = 0; a < 2**AW; a++) begin
         mcycle(0, 1, AW'(a), '1, $urandom);
         repeat (L) mcycle(0, 0, '0, '0, '0);
      end
      for (int i = 0; i < 1500; i++) begin
         mcycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                AW'($urandom), NB'($urandom), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
